// File: rtl/wb_xbar_arb.sv
// wb_xbar_arb: shared-bus Wishbone classic interconnect.
// Round-robin arbitration between NUM_MASTERS masters, table-driven slave decode,
// ERR for unmapped addresses and a per-transfer watchdog that forces ERR on a hung slave.
module wb_xbar_arb #(
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {NUM_SLAVES{32'h0}},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                CLK_I,
    input  logic                                RST_I,
    input  logic [NUM_MASTERS-1:0]              M_CYC_I,
    input  logic [NUM_MASTERS-1:0]              M_STB_I,
    input  logic [NUM_MASTERS-1:0]              M_WE_I,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   M_ADR_I,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   M_DAT_I,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] M_SEL_I,
    output logic [DATA_WIDTH-1:0]               M_DAT_O,
    output logic [NUM_MASTERS-1:0]              M_ACK_O,
    output logic [NUM_MASTERS-1:0]              M_ERR_O,
    output logic [NUM_SLAVES-1:0]               S_CYC_O,
    output logic [NUM_SLAVES-1:0]               S_STB_O,
    output logic [ADDR_WIDTH-1:0]               S_ADR_O,
    output logic                                S_WE_O,
    output logic [DATA_WIDTH-1:0]               S_DAT_O,
    output logic [DATA_WIDTH/8-1:0]             S_SEL_O,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]    S_DAT_I,
    input  logic [NUM_SLAVES-1:0]               S_ACK_I,
    input  logic [NUM_SLAVES-1:0]               S_ERR_I,
    output logic [NUM_MASTERS-1:0]              GNT_O,
    output logic                                TIMEOUT_O
);

    localparam int MW   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int WDW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SELW = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [MW-1:0]          gnt_idx_q, gnt_idx_d;
    logic [MW-1:0]          rr_q, rr_d;
    logic [WDW-1:0]         wd_q, wd_d;
    logic                   timeout_q, timeout_d;

    logic                   g_cyc, g_stb, g_we;
    logic [ADDR_WIDTH-1:0]  g_adr;
    logic [DATA_WIDTH-1:0]  g_dat;
    logic [SELW-1:0]        g_sel;
    logic                   hit_found;
    logic [SW-1:0]          hit_idx;
    logic                   s_ack, s_err;
    logic [DATA_WIDTH-1:0]  s_rdat;
    logic                   wd_fire;
    logic                   arb_found;
    logic [MW-1:0]          arb_win;
    int                     arb_pos;

    // Select the granted master's request and decode it to the lowest-index matching slave.
    always_comb begin
        g_cyc     = 1'b0;
        g_stb     = 1'b0;
        g_we      = 1'b0;
        g_adr     = '0;
        g_dat     = '0;
        g_sel     = '0;
        hit_found = 1'b0;
        hit_idx   = '0;
        s_ack     = 1'b0;
        s_err     = 1'b0;
        s_rdat    = '0;
        if (state_q != ST_IDLE) begin
            g_cyc = M_CYC_I[gnt_idx_q];
            g_stb = M_STB_I[gnt_idx_q];
            g_we  = M_WE_I[gnt_idx_q];
            g_adr = M_ADR_I[int'(gnt_idx_q)*ADDR_WIDTH +: ADDR_WIDTH];
            g_dat = M_DAT_I[int'(gnt_idx_q)*DATA_WIDTH +: DATA_WIDTH];
            g_sel = M_SEL_I[int'(gnt_idx_q)*SELW +: SELW];
        end
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (!hit_found &&
                ((g_adr & SLAVE_MASK[s*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[s*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit_found = 1'b1;
                hit_idx   = SW'(s);
            end
        end
        if (state_q == ST_GRANT && hit_found) begin
            s_rdat = S_DAT_I[int'(hit_idx)*DATA_WIDTH +: DATA_WIDTH];
            if (g_cyc && g_stb) begin
                s_ack = S_ACK_I[hit_idx];
                s_err = S_ERR_I[hit_idx];
            end
        end
    end

    // Watchdog fires on the last strobed cycle that would reach TIMEOUT_CYCLES without a response.
    always_comb begin
        wd_fire = (state_q == ST_GRANT) && g_cyc && g_stb && hit_found && !s_ack && !s_err &&
                  (wd_q == WDW'(TIMEOUT_CYCLES - 1));
    end

    // Round-robin search for the first requesting master at or after the rr pointer.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_pos   = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            arb_pos = (int'(rr_q) + i) % NUM_MASTERS;
            if (!arb_found && M_CYC_I[arb_pos]) begin
                arb_found = 1'b1;
                arb_win   = MW'(arb_pos);
            end
        end
    end

    // Next-state logic for the IDLE/GRANT/ERR controller, grant, rr pointer and watchdog.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        rr_d      = rr_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                wd_d      = '0;
                timeout_d = 1'b0;
                if (arb_found) begin
                    state_d   = ST_GRANT;
                    gnt_idx_d = arb_win;
                    gnt_d     = NUM_MASTERS'(1) << arb_win;
                end
            end
            ST_GRANT: begin
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    rr_d    = (gnt_idx_q == MW'(NUM_MASTERS - 1)) ? '0 : gnt_idx_q + MW'(1);
                    wd_d    = '0;
                end else if (g_stb && !hit_found) begin
                    state_d   = ST_ERR;
                    timeout_d = 1'b0;
                    wd_d      = '0;
                end else if (wd_fire) begin
                    state_d   = ST_ERR;
                    timeout_d = 1'b1;
                    wd_d      = '0;
                end else if (g_stb && !s_ack && !s_err) begin
                    wd_d = wd_q + WDW'(1);
                end else begin
                    wd_d = '0;
                end
            end
            ST_ERR: begin
                timeout_d = 1'b0;
                wd_d      = '0;
                if (!g_cyc) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    rr_d    = (gnt_idx_q == MW'(NUM_MASTERS - 1)) ? '0 : gnt_idx_q + MW'(1);
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            rr_q      <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            rr_q      <= rr_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    // Drive the shared slave bus, the hit slave's handshake and the granted master's response.
    always_comb begin
        S_ADR_O   = g_adr;
        S_WE_O    = g_we;
        S_DAT_O   = g_dat;
        S_SEL_O   = g_sel;
        S_CYC_O   = '0;
        S_STB_O   = '0;
        M_DAT_O   = s_rdat;
        M_ACK_O   = '0;
        M_ERR_O   = '0;
        GNT_O     = gnt_q;
        TIMEOUT_O = (state_q == ST_ERR) && timeout_q;
        if (state_q == ST_GRANT) begin
            if (hit_found) begin
                S_CYC_O[hit_idx] = g_cyc;
                S_STB_O[hit_idx] = g_stb;
            end
            M_ACK_O[gnt_idx_q] = s_ack && !s_err;
            M_ERR_O[gnt_idx_q] = s_err;
        end else if (state_q == ST_ERR) begin
            M_ERR_O[gnt_idx_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_xbar_arb.sv
// tb_wb_xbar_arb: directed bench for the Wishbone interconnect with a small
// scoreboard of expected read/write data.
module tb_wb_xbar_arb;

    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic                 CLK_I = 1'b0;
    logic                 RST_I;
    logic [NM-1:0]        M_CYC_I, M_STB_I, M_WE_I;
    logic [NM*AW-1:0]     M_ADR_I;
    logic [NM*DW-1:0]     M_DAT_I;
    logic [NM*DW/8-1:0]   M_SEL_I;
    logic [DW-1:0]        M_DAT_O;
    logic [NM-1:0]        M_ACK_O, M_ERR_O;
    logic [NS-1:0]        S_CYC_O, S_STB_O;
    logic [AW-1:0]        S_ADR_O;
    logic                 S_WE_O;
    logic [DW-1:0]        S_DAT_O;
    logic [DW/8-1:0]      S_SEL_O;
    logic [NS*DW-1:0]     S_DAT_I;
    logic [NS-1:0]        S_ACK_I, S_ERR_I;
    logic [NM-1:0]        GNT_O;
    logic                 TIMEOUT_O;

    typedef struct {
        string       tag;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   exp_rr;
    int   granted;
    int   stb_cycles;
    bit   seen_err;

    wb_xbar_arb #(
        .NUM_MASTERS   (NM),
        .NUM_SLAVES    (NS),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .SLAVE_BASE    ({32'h8000_0000, 32'h0000_0000}),
        .SLAVE_MASK    ({32'hFFFF_FF00, 32'hFFFF_F000}),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .M_CYC_I  (M_CYC_I),
        .M_STB_I  (M_STB_I),
        .M_WE_I   (M_WE_I),
        .M_ADR_I  (M_ADR_I),
        .M_DAT_I  (M_DAT_I),
        .M_SEL_I  (M_SEL_I),
        .M_DAT_O  (M_DAT_O),
        .M_ACK_O  (M_ACK_O),
        .M_ERR_O  (M_ERR_O),
        .S_CYC_O  (S_CYC_O),
        .S_STB_O  (S_STB_O),
        .S_ADR_O  (S_ADR_O),
        .S_WE_O   (S_WE_O),
        .S_DAT_O  (S_DAT_O),
        .S_SEL_O  (S_SEL_O),
        .S_DAT_I  (S_DAT_I),
        .S_ACK_I  (S_ACK_I),
        .S_ERR_I  (S_ERR_I),
        .GNT_O    (GNT_O),
        .TIMEOUT_O(TIMEOUT_O)
    );

    // Free-running clock, 10 time-unit period.
    always #5 CLK_I = ~CLK_I;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest scoreboard entry and compare it with the DUT's data.
    task automatic popCheck(input string where, input logic [31:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected <empty scoreboard>", where, obs);
        end else begin
            e = sbq.pop_front();
            checkOutput({where, "/", e.tag}, {32'h0, obs}, {32'h0, e.data});
        end
    endtask

    // Drive one master's request lines.
    task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        M_CYC_I[m]          = cyc;
        M_STB_I[m]          = stb;
        M_WE_I[m]           = we;
        M_ADR_I[m*AW +: AW] = adr;
        M_DAT_I[m*DW +: DW] = dat;
        M_SEL_I[m*4 +: 4]   = sel;
    endtask

    // Directed sequence of bus scenarios.
    initial begin
        RST_I   = 1'b1;
        M_CYC_I = '0;
        M_STB_I = '0;
        M_WE_I  = '0;
        M_ADR_I = '0;
        M_DAT_I = '0;
        M_SEL_I = '0;
        S_DAT_I = '0;
        S_ACK_I = '0;
        S_ERR_I = '0;
        tick();
        tick();
        #1;
        checkOutput("rst_gnt",     {62'h0, GNT_O},   64'h0);
        checkOutput("rst_scyc",    {62'h0, S_CYC_O}, 64'h0);
        checkOutput("rst_sstb",    {62'h0, S_STB_O}, 64'h0);
        checkOutput("rst_mack",    {62'h0, M_ACK_O}, 64'h0);
        checkOutput("rst_merr",    {62'h0, M_ERR_O}, 64'h0);
        checkOutput("rst_timeout", {63'h0, TIMEOUT_O}, 64'h0);
        checkOutput("rst_sadr",    {32'h0, S_ADR_O}, 64'h0);
        checkOutput("rst_mdat",    {32'h0, M_DAT_O}, 64'h0);
        RST_I = 1'b0;
        tick();

        // M0 read from slave0
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        sbq.push_back('{tag: "m0_read", data: 32'hDEADBEEF});
        #1;
        checkOutput("arb_latency", {62'h0, GNT_O}, 64'h0);
        tick();
        #1;
        checkOutput("read_gnt",  {62'h0, GNT_O},   64'h1);
        checkOutput("read_sstb", {62'h0, S_STB_O}, 64'h1);
        checkOutput("read_scyc", {62'h0, S_CYC_O}, 64'h1);
        S_ACK_I = 2'b10;
        #1;
        checkOutput("spurious_ack", {62'h0, M_ACK_O}, 64'h0);
        S_ACK_I        = 2'b01;
        S_DAT_I[31:0]  = 32'hDEAD_BEEF;
        #1;
        checkOutput("read_ack", {62'h0, M_ACK_O}, 64'h1);
        if (M_ACK_O[0]) popCheck("read_data", M_DAT_O);
        tick();
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        S_ACK_I = '0;
        S_DAT_I = '0;
        tick();
        #1;
        checkOutput("read_release", {62'h0, GNT_O}, 64'h0);

        // M0 and M1 contend; grants rotate with an idle cycle between them
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
        exp_rr = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            checkOutput($sformatf("rr_grant%0d", k), {62'h0, GNT_O}, 64'h1 << exp_rr);
            granted          = exp_rr;
            M_CYC_I[granted] = 1'b0;
            exp_rr           = (granted + 1) % NM;
            tick();
            #1;
            checkOutput($sformatf("rr_idle%0d", k), {62'h0, GNT_O}, 64'h0);
            M_CYC_I = (k < 2) ? 2'b11 : 2'b00;
        end

        // M1 write to slave1
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h8000_0004, 32'h1234_5678, 4'hC);
        sbq.push_back('{tag: "m1_write", data: 32'h1234_5678});
        tick();
        #1;
        checkOutput("wr_gnt",  {62'h0, GNT_O},   64'h2);
        checkOutput("wr_sstb", {62'h0, S_STB_O}, 64'h2);
        checkOutput("wr_scyc", {62'h0, S_CYC_O}, 64'h2);
        checkOutput("wr_sadr", {32'h0, S_ADR_O}, 64'h8000_0004);
        checkOutput("wr_swe",  {63'h0, S_WE_O},  64'h1);
        checkOutput("wr_ssel", {60'h0, S_SEL_O}, 64'hC);
        if (S_STB_O[1]) popCheck("wr_sdat", S_DAT_O);
        S_ACK_I = 2'b10;
        #1;
        checkOutput("wr_ack", {62'h0, M_ACK_O}, 64'h2);
        tick();
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        S_ACK_I = '0;
        tick();
        #1;
        checkOutput("wr_release", {62'h0, GNT_O}, 64'h0);

        // M0 to unmapped address
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'hF);
        tick();
        #1;
        checkOutput("unm_gnt",  {62'h0, GNT_O},   64'h1);
        checkOutput("unm_sstb", {62'h0, S_STB_O}, 64'h0);
        checkOutput("unm_scyc", {62'h0, S_CYC_O}, 64'h0);
        checkOutput("unm_noerr_yet", {62'h0, M_ERR_O}, 64'h0);
        tick();
        #1;
        checkOutput("unm_err",      {62'h0, M_ERR_O}, 64'h1);
        checkOutput("unm_err_sstb", {62'h0, S_STB_O}, 64'h0);
        M_STB_I[0] = 1'b0;
        tick();
        #1;
        checkOutput("unm_err_once", {62'h0, M_ERR_O}, 64'h0);
        M_CYC_I[0] = 1'b0;
        tick();

        // Slave0 never responds: watchdog
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF);
        tick();
        stb_cycles = 0;
        seen_err   = 1'b0;
        for (int i = 0; i < 20 && !seen_err; i++) begin
            #1;
            if (M_ERR_O[0]) begin
                seen_err = 1'b1;
            end else begin
                if (S_STB_O[0]) stb_cycles++;
                tick();
            end
        end
        checkOutput("wd_stb_cycles", 64'(stb_cycles),    64'(TO));
        checkOutput("wd_err",        {62'h0, M_ERR_O},   64'h1);
        checkOutput("wd_timeout",    {63'h0, TIMEOUT_O}, 64'h1);
        checkOutput("wd_sstb_off",   {62'h0, S_STB_O},   64'h0);
        M_STB_I[0] = 1'b0;
        tick();
        #1;
        checkOutput("wd_timeout_once", {63'h0, TIMEOUT_O}, 64'h0);
        checkOutput("wd_err_once",     {62'h0, M_ERR_O},   64'h0);
        M_CYC_I[0] = 1'b0;
        tick();

        // Reset while M1 is granted; M0 wins first afterwards
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'hF);
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 4'hF);
        tick();
        #1;
        checkOutput("pre_rst_gnt",  {62'h0, GNT_O},   64'h2);
        checkOutput("pre_rst_sstb", {62'h0, S_STB_O}, 64'h2);
        RST_I = 1'b1;
        tick();
        #1;
        checkOutput("mid_rst_gnt",  {62'h0, GNT_O},   64'h0);
        checkOutput("mid_rst_sstb", {62'h0, S_STB_O}, 64'h0);
        checkOutput("mid_rst_scyc", {62'h0, S_CYC_O}, 64'h0);
        checkOutput("mid_rst_mack", {62'h0, M_ACK_O}, 64'h0);
        RST_I = 1'b0;
        tick();
        #1;
        checkOutput("post_rst_gnt", {62'h0, GNT_O}, 64'h1);

        // Slave0 asserts ACK and ERR together: ERR wins
        S_ACK_I = 2'b01;
        S_ERR_I = 2'b01;
        #1;
        checkOutput("errwin_ack", {62'h0, M_ACK_O}, 64'h0);
        checkOutput("errwin_err", {62'h0, M_ERR_O}, 64'h1);
        tick();
        M_CYC_I = '0;
        M_STB_I = '0;
        S_ACK_I = '0;
        S_ERR_I = '0;
        tick();
        tick();

        checkOutput("sb_empty", 64'(sbq.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
